stream_mux4: RTL and testbench



---
 rtl/stream_mux4.sv | 95 +++++++++
 tb/tb_stream_mux4.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/stream_mux4.sv
`timescale 1ns/1ps
// stream_mux4 - 4-to-1 valid/ready stream multiplexer with round-robin
// arbitration and a single registered output stage.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    channel i data in bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel word offered
//   in_ready   per-channel word accepted this cycle (at most one bit high)
//   out_data   registered output word
//   out_sel    channel index the out_data word came from
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word this cycle
module stream_mux4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_valid,
    output logic [3:0]         in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       last_grant_q, last_grant_d;

    logic [3:0]       grant;
    logic [1:0]       grant_idx;
    logic [1:0]       scan_idx;
    logic             found;
    logic             load_en;

    // The register can take a new word when empty or when its word drains this cycle.
    assign load_en = !out_valid_q || out_ready;

    // Round-robin scan starting one past the last granted channel.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant_q;
        found     = 1'b0;
        scan_idx  = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            scan_idx = last_grant_q + 2'(i);
            if (!found && in_valid[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
            end
        end
    end

    // rst_n gating keeps producers from seeing an accept while in reset.
    assign in_ready = grant & {4{load_en & rst_n}};

    always_comb begin
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (load_en && found) begin
            out_data_d   = in_data[grant_idx*WIDTH +: WIDTH];
            out_sel_d    = grant_idx;
            out_valid_d  = 1'b1;
            last_grant_d = grant_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= 2'd3;
        end else begin
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux4.sv
`timescale 1ns/1ps
module tb_stream_mux4;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    stream_mux4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = $urandom;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d expected 0", out_sel); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b expected 0000", in_ready); end
        rst_n    = 1'b1;
        in_valid = 4'b0001;
        in_data  = 32'h0000_0077;
        tick();
        checks++; if (out_data !== 8'h77 || out_valid !== 1'b1) begin errors++; $display("FAIL pre_async_load got %h/%b expected 77/1", out_data, out_valid); end
        in_valid = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL async_reset got %h/%b expected 00/0", out_data, out_valid); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        in_valid  = 4'b0100;
        in_data   = 32'h0000_0000;
        in_data[16 +: 8] = 8'hA5;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_in_ready got %b expected 0100", in_ready); end
        tick();
        in_valid = 4'b0000;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2) begin errors++; $display("FAIL single_out got %b/%h/%0d expected 1/a5/2", out_valid, out_data, out_sel); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b expected 0", out_valid); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        in_data   = 32'h1312_1110;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (in_ready !== (4'b0001 << (i % 4))) begin errors++; $display("FAIL rr_in_ready[%0d] got %b expected %b", i, in_ready, 4'b0001 << (i % 4)); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== 8'(8'h10 + i % 4)) begin
                errors++; $display("FAIL rr_out[%0d] got %b/%0d/%h expected 1/%0d/%h", i, out_valid, out_sel, out_data, i % 4, 8'h10 + i % 4);
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        in_data   = 32'hC2B2_3CA2;
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 8'h3C || out_sel !== 2'd1) begin errors++; $display("FAIL bp_load got %h/%0d expected 3c/1", out_data, out_sel); end
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d] got %b expected 0000", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 2'd1) begin
                errors++; $display("FAIL bp_hold[%0d] got %b/%h/%0d expected 1/3c/1", i, out_valid, out_data, out_sel);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b expected 0100", in_ready); end
        tick();
        checks++; if (out_sel !== 2'd2 || out_data !== 8'hB2) begin errors++; $display("FAIL bp_release_out got %0d/%h expected 2/b2", out_sel, out_data); end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_skip_idle();
        logic [1:0] exp_sel [4];
        exp_sel = '{2'd3, 2'd0, 2'd3, 2'd0};
        apply_reset();
        in_data   = 32'hD300_00D0;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        tick();
        checks++; if (out_sel !== 2'd0 || out_data !== 8'hD0) begin errors++; $display("FAIL skip_first got %0d/%h expected 0/d0", out_sel, out_data); end
        in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_sel !== exp_sel[i] || out_data !== (exp_sel[i] == 2'd3 ? 8'hD3 : 8'hD0)) begin
                errors++; $display("FAIL skip_seq[%0d] got %b/%0d/%h expected 1/%0d", i, out_valid, out_sel, out_data, exp_sel[i]);
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_full();
        in_data   = 32'h4400_0000;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        tick();
        in_valid = 4'b0000;
        tick();
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2) begin errors++; $display("FAIL full_hold got %b/%0d expected 1/2", out_valid, out_sel); end
        rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_reset_valid got %b expected 0", out_valid); end
        tick();
        rst_n    = 1'b1;
        in_data  = 32'h5352_5150;
        in_valid = 4'b1111;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 4'b0001) begin errors++; $display("FAIL full_post_reset got %b/%b expected 0/0001", out_valid, in_ready); end
        tick();
        checks++; if (out_sel !== 2'd0 || out_data !== 8'h50) begin errors++; $display("FAIL full_first_grant got %0d/%h expected 0/50", out_sel, out_data); end
        in_valid = 4'b0000;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_skip_idle();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
